// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg: shared types for the hsv core pipeline.
// Adds the commit-stage result bundle, commit FSM states and unit count.
package hsv_core_pkg;

  localparam int NUM_COMMIT_UNITS = 5;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    reg_addr_t rd;
    word_t     result;
    logic      wb_en;
    logic      redirect;
    word_t     redirect_pc;
  } commit_data_t;

  typedef enum logic {
    COMMIT_RUN   = 1'b0,
    COMMIT_FLUSH = 1'b1
  } commit_state_t;

  function automatic word_t rd_onehot(reg_addr_t rd);
    return word_t'(1) << rd;
  endfunction

endpackage

// File: rtl/hsv_core_commit_rr_arbiter.sv
// hsv_core_commit_rr_arbiter: round-robin one-hot grant with pointer.
// Ports: clk/rst, i_req, i_en (grant allowed), i_clear (ptr->0), o_grant.
module hsv_core_commit_rr_arbiter #(
  parameter int NUM_UNITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_UNITS-1:0] i_req,
  input  logic                 i_en,
  input  logic                 i_clear,
  output logic [NUM_UNITS-1:0] o_grant
);

  localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [PW:0]   NU  = (PW+1)'(NUM_UNITS);
  localparam logic [PW-1:0] TOP = PW'(NUM_UNITS - 1);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;
  logic [PW:0]   w_idx;
  logic [PW-1:0] w_sel;
  logic          w_any;

  // Scan from the pointer, wrapping; first requester wins.
  always_comb begin
    o_grant    = '0;
    w_next_ptr = r_ptr;
    w_any      = 1'b0;
    w_idx      = '0;
    w_sel      = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_idx >= NU)
        w_idx = w_idx - NU;
      w_sel = w_idx[PW-1:0];
      if (i_en && !w_any && i_req[w_sel]) begin
        o_grant[w_sel] = 1'b1;
        w_any          = 1'b1;
        w_next_ptr     = (w_sel == TOP) ? '0 : w_sel + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (i_clear)
      r_ptr <= '0;
    else if (w_any)
      r_ptr <= w_next_ptr;
  end

endmodule

// File: rtl/hsv_core_commit.sv
// hsv_core_commit: commit/writeback stage, RR over result channels,
// regfile write + commit_mask, flush_req/flush_ack redirect handshake.
// Ports: clk_core, rst_core, unit_valid_i/ready_o/data_i, wr_addr,
// wr_data, wr_en, commit_mask, flush_req, flush_ack, redirect_pc,
// retired_count (only with HSV_COMMIT_RETIRE_COUNT_EN defined).
module hsv_core_commit
  import hsv_core_pkg::*;
#(
  parameter int NUM_UNITS = NUM_COMMIT_UNITS,
  parameter int COUNT_W   = 64
) (
  input  logic                                   clk_core,
  input  logic                                   rst_core,
  input  logic [NUM_UNITS-1:0]                   unit_valid_i,
  output logic [NUM_UNITS-1:0]                   unit_ready_o,
  input  logic [NUM_UNITS*$bits(commit_data_t)-1:0] unit_data_i,
  output logic [4:0]                             wr_addr,
  output logic [31:0]                            wr_data,
  output logic                                   wr_en,
  output logic [31:0]                            commit_mask,
  output logic                                   flush_req,
  input  logic                                   flush_ack,
  output logic [31:0]                            redirect_pc
`ifdef HSV_COMMIT_RETIRE_COUNT_EN
  ,
  output logic [COUNT_W-1:0]                     retired_count
`endif
);

  localparam int DW = $bits(commit_data_t);

  commit_state_t  r_state;
  logic           r_flush_d;
  logic [NUM_UNITS-1:0] w_grant;
  logic [DW-1:0]  w_sel_bits;
  commit_data_t   w_sel;
  logic           w_run;
  logic           w_xfer;
  logic           w_we;
  logic           w_exit;

  assign w_run     = (r_state == COMMIT_RUN);
  assign flush_req = (r_state == COMMIT_FLUSH);

  hsv_core_commit_rr_arbiter #(
    .NUM_UNITS (NUM_UNITS)
  ) u_arb (
    .clk     (clk_core),
    .rst     (rst_core),
    .i_req   (unit_valid_i),
    .i_en    (w_run & ~rst_core),
    .i_clear (w_exit),
    .o_grant (w_grant)
  );

  assign unit_ready_o = w_grant;
  assign w_xfer       = |(unit_valid_i & w_grant);

  always_comb begin
    w_sel_bits = '0;
    for (int k = 0; k < NUM_UNITS; k++)
      w_sel_bits = w_sel_bits
                 | (unit_data_i[k*DW +: DW] & {DW{w_grant[k]}});
  end

  assign w_sel = commit_data_t'(w_sel_bits);
  assign w_we  = w_xfer & w_sel.wb_en & (w_sel.rd != '0);

  // An ack only counts once req was already high last cycle;
  // issue's ack lags req by one cycle, so earlier acks are stale.
  assign w_exit = flush_req & flush_ack & r_flush_d;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_state     <= COMMIT_RUN;
      r_flush_d   <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      commit_mask <= '0;
      redirect_pc <= '0;
    end else begin
      r_flush_d   <= flush_req;
      wr_en       <= w_we;
      commit_mask <= w_we ? rd_onehot(w_sel.rd) : '0;
      if (w_xfer) begin
        wr_addr <= w_sel.rd;
        wr_data <= w_sel.result;
      end
      unique case (r_state)
        COMMIT_RUN: begin
          if (w_xfer && w_sel.redirect) begin
            r_state     <= COMMIT_FLUSH;
            redirect_pc <= w_sel.redirect_pc;
          end
        end
        COMMIT_FLUSH: begin
          if (w_exit)
            r_state <= COMMIT_RUN;
        end
      endcase
    end
  end

`ifdef HSV_COMMIT_RETIRE_COUNT_EN
  logic [COUNT_W-1:0] r_retired;

  always_ff @(posedge clk_core) begin
    if (rst_core)
      r_retired <= '0;
    else if (w_xfer)
      r_retired <= r_retired + COUNT_W'(1);
  end

  assign retired_count = r_retired;
`else
  logic w_unused_count_w;
  assign w_unused_count_w = ^COUNT_W;
`endif

endmodule

// File: tb/tb_hsv_core_commit.sv
// tb_hsv_core_commit: directed + randomized bench for hsv_core_commit.
// Random phase checks against a queue-level reference model.
module tb_hsv_core_commit;
  import hsv_core_pkg::*;

  localparam int N  = 5;
  localparam int DW = $bits(commit_data_t);

  logic              clk_core = 1'b0;
  logic              rst_core;
  logic [N-1:0]      unit_valid_i;
  logic [N-1:0]      unit_ready_o;
  logic [N*DW-1:0]   unit_data_i;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data;
  logic              wr_en;
  logic [31:0]       commit_mask;
  logic              flush_req;
  logic              flush_ack;
  logic [31:0]       redirect_pc;
`ifdef HSV_COMMIT_RETIRE_COUNT_EN
  logic [63:0]       retired_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_core = ~clk_core;

  hsv_core_commit dut (
    .clk_core     (clk_core),
    .rst_core     (rst_core),
    .unit_valid_i (unit_valid_i),
    .unit_ready_o (unit_ready_o),
    .unit_data_i  (unit_data_i),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .commit_mask  (commit_mask),
    .flush_req    (flush_req),
    .flush_ack    (flush_ack),
    .redirect_pc  (redirect_pc)
`ifdef HSV_COMMIT_RETIRE_COUNT_EN
    ,
    .retired_count(retired_count)
`endif
  );

  task automatic drive(input int k, input logic v, input logic [4:0] rd,
                       input logic [31:0] res, input logic wb,
                       input logic redir, input logic [31:0] pc);
    commit_data_t d;
    d.rd = rd; d.result = res; d.wb_en = wb;
    d.redirect = redir; d.redirect_pc = pc;
    unit_valid_i[k] = v;
    unit_data_i[k*DW +: DW] = d;
  endtask

  task automatic idle();
    unit_valid_i = '0;
    flush_ack    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic do_reset();
    rst_core = 1'b1;
    idle();
    tick();
    rst_core = 1'b0;
  endtask

  task automatic test_reset();
    rst_core = 1'b1;
    unit_valid_i = '1;
    #1;
    n_cmp++;
    if (unit_ready_o !== 5'b0) begin
      n_err++; $display("FAIL reset_ready got %b want 00000", unit_ready_o);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b0 || commit_mask !== 32'h0) begin
      n_err++; $display("FAIL reset_wb got en=%b mask=%h want 0/0", wr_en, commit_mask);
    end
    n_cmp++;
    if (wr_addr !== 5'd0 || wr_data !== 32'h0) begin
      n_err++; $display("FAIL reset_addr_data got %0d/%h want 0/0", wr_addr, wr_data);
    end
    n_cmp++;
    if (flush_req !== 1'b0 || redirect_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_flush got req=%b pc=%h want 0/0", flush_req, redirect_pc);
    end
`ifdef HSV_COMMIT_RETIRE_COUNT_EN
    n_cmp++;
    if (retired_count !== 64'd0) begin
      n_err++; $display("FAIL reset_retired got %0d want 0", retired_count);
    end
`endif
    rst_core = 1'b0;
    idle();
  endtask

  task automatic test_single();
    do_reset();
    drive(0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    #1;
    n_cmp++;
    if (unit_ready_o !== 5'b00001) begin
      n_err++; $display("FAIL single_ready got %b want 00001", unit_ready_o);
    end
    tick();
    idle();
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_wb got en=%b a=%0d d=%h want 1/5/deadbeef",
                        wr_en, wr_addr, wr_data);
    end
    n_cmp++;
    if (commit_mask !== 32'h20) begin
      n_err++; $display("FAIL single_mask got %h want 00000020", commit_mask);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b0 || commit_mask !== 32'h0) begin
      n_err++; $display("FAIL single_one_cycle got en=%b mask=%h want 0/0", wr_en, commit_mask);
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive(2, 1'b1, 5'd0, 32'h1234, 1'b1, 1'b0, 32'h0);
    tick();
    idle();
    n_cmp++;
    if (wr_en !== 1'b0 || commit_mask !== 32'h0) begin
      n_err++; $display("FAIL x0_suppress got en=%b mask=%h want 0/0", wr_en, commit_mask);
    end
`ifdef HSV_COMMIT_RETIRE_COUNT_EN
    n_cmp++;
    if (retired_count !== 64'd1) begin
      n_err++; $display("FAIL x0_retired got %0d want 1", retired_count);
    end
`endif
    drive(1, 1'b1, 5'd7, 32'h5555, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    n_cmp++;
    if (wr_en !== 1'b0 || commit_mask !== 32'h0) begin
      n_err++; $display("FAIL nowb_suppress got en=%b mask=%h want 0/0", wr_en, commit_mask);
    end
`ifdef HSV_COMMIT_RETIRE_COUNT_EN
    n_cmp++;
    if (retired_count !== 64'd2) begin
      n_err++; $display("FAIL nowb_retired got %0d want 2", retired_count);
    end
`endif
  endtask

  task automatic test_round_robin();
    int cnt[N];
    logic [N-1:0] er;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < N; k++)
        drive(k, 1'b1, 5'(k + 1), 32'(c * 16 + k), 1'b1, 1'b0, 32'h0);
      #1;
      er = '0;
      er[c % N] = 1'b1;
      n_cmp++;
      if (unit_ready_o !== er) begin
        n_err++; $display("FAIL rr_grant c=%0d got %b want %b", c, unit_ready_o, er);
      end
      for (int k = 0; k < N; k++)
        if (unit_ready_o[k]) cnt[k]++;
      tick();
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== 5'((c % N) + 1)) begin
        n_err++; $display("FAIL rr_wb c=%0d got en=%b a=%0d want 1/%0d",
                          c, wr_en, wr_addr, (c % N) + 1);
      end
    end
    idle();
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (cnt[k] != 2) begin
        n_err++; $display("FAIL rr_starve unit=%0d got %0d grants want 2", k, cnt[k]);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(3, 1'b1, 5'd1, 32'h1111, 1'b1, 1'b1, 32'h80000100);
    drive(4, 1'b1, 5'd9, 32'h9999, 1'b1, 1'b0, 32'h0);
    #1;
    n_cmp++;
    if (unit_ready_o !== 5'b01000) begin
      n_err++; $display("FAIL redir_grant got %b want 01000", unit_ready_o);
    end
    tick();
    unit_valid_i[3] = 1'b0;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd1 || commit_mask !== 32'h2) begin
      n_err++; $display("FAIL redir_wb got en=%b a=%0d m=%h want 1/1/2",
                        wr_en, wr_addr, commit_mask);
    end
    n_cmp++;
    if (flush_req !== 1'b1 || redirect_pc !== 32'h80000100) begin
      n_err++; $display("FAIL redir_flush got req=%b pc=%h want 1/80000100",
                        flush_req, redirect_pc);
    end
    n_cmp++;
    if (unit_ready_o !== 5'b0) begin
      n_err++; $display("FAIL redir_hold got %b want 00000", unit_ready_o);
    end
    tick();
    n_cmp++;
    if (flush_req !== 1'b1 || unit_ready_o !== 5'b0) begin
      n_err++; $display("FAIL redir_wait got req=%b rdy=%b want 1/00000",
                        flush_req, unit_ready_o);
    end
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    n_cmp++;
    if (flush_req !== 1'b0) begin
      n_err++; $display("FAIL redir_exit got req=%b want 0", flush_req);
    end
    unit_valid_i = '1;
    #1;
    n_cmp++;
    if (unit_ready_o !== 5'b00001) begin
      n_err++; $display("FAIL redir_ptr0 got %b want 00001", unit_ready_o);
    end
    idle();
  endtask

  task automatic test_stale_ack();
    do_reset();
    flush_ack = 1'b1;
    drive(3, 1'b1, 5'd2, 32'h2222, 1'b1, 1'b1, 32'h80000200);
    tick();
    unit_valid_i = '0;
    n_cmp++;
    if (flush_req !== 1'b1) begin
      n_err++; $display("FAIL stale_enter got req=%b want 1", flush_req);
    end
    tick();
    n_cmp++;
    if (flush_req !== 1'b1) begin
      n_err++; $display("FAIL stale_ignored got req=%b want 1", flush_req);
    end
    tick();
    n_cmp++;
    if (flush_req !== 1'b0) begin
      n_err++; $display("FAIL stale_exit got req=%b want 0", flush_req);
    end
    idle();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    drive(1, 1'b1, 5'd3, 32'h3333, 1'b1, 1'b1, 32'hCAFE0000);
    tick();
    idle();
    n_cmp++;
    if (flush_req !== 1'b1) begin
      n_err++; $display("FAIL rmf_enter got req=%b want 1", flush_req);
    end
    rst_core = 1'b1;
    tick();
    rst_core = 1'b0;
    n_cmp++;
    if (flush_req !== 1'b0 || redirect_pc !== 32'h0) begin
      n_err++; $display("FAIL rmf_flush got req=%b pc=%h want 0/0", flush_req, redirect_pc);
    end
    n_cmp++;
    if (wr_en !== 1'b0 || commit_mask !== 32'h0 || wr_addr !== 5'd0 || wr_data !== 32'h0) begin
      n_err++; $display("FAIL rmf_wb got en=%b m=%h a=%0d d=%h want zeros",
                        wr_en, commit_mask, wr_addr, wr_data);
    end
    drive(2, 1'b1, 5'd4, 32'h4444, 1'b1, 1'b0, 32'h0);
    #1;
    n_cmp++;
    if (unit_ready_o !== 5'b00100) begin
      n_err++; $display("FAIL rmf_run got %b want 00100", unit_ready_o);
    end
    idle();
  endtask

  task automatic test_random();
    bit           pend[N];
    commit_data_t pd[N];
    int           ptr, g, idx;
    bit           m_flush, m_flush_prev, n_flush, ex;
    longint       m_ret;
    logic         e_we;
    logic [31:0]  e_mask, e_data, e_pc;
    logic [4:0]   e_addr;
    logic [N-1:0] er;
    do_reset();
    for (int k = 0; k < N; k++) pend[k] = 0;
    ptr = 0; m_flush = 0; m_flush_prev = 0; m_ret = 0;
    e_pc = '0; e_addr = '0; e_data = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1;
          pd[k].rd = 5'($urandom);
          pd[k].result = $urandom;
          pd[k].wb_en = ($urandom_range(0, 3) != 0);
          pd[k].redirect = ($urandom_range(0, 7) == 0);
          pd[k].redirect_pc = $urandom;
        end
        unit_valid_i[k] = pend[k];
        unit_data_i[k*DW +: DW] = pd[k];
      end
      flush_ack = 1'($urandom_range(0, 1));
      #1;
      g = -1;
      if (!m_flush)
        for (int i = 0; i < N; i++) begin
          idx = (ptr + i) % N;
          if (g < 0 && pend[idx]) g = idx;
        end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      n_cmp++;
      if (unit_ready_o !== er) begin
        n_err++; $display("FAIL rand_ready c=%0d got %b want %b", c, unit_ready_o, er);
      end
      ex = m_flush && flush_ack && m_flush_prev;
      n_flush = m_flush;
      if (g >= 0) begin
        e_we   = pd[g].wb_en && (pd[g].rd != 0);
        e_mask = e_we ? (32'd1 << pd[g].rd) : 32'd0;
        e_addr = pd[g].rd;
        e_data = pd[g].result;
        if (pd[g].redirect) begin
          n_flush = 1;
          e_pc = pd[g].redirect_pc;
        end
        ptr = (g + 1) % N;
        pend[g] = 0;
        m_ret++;
      end else begin
        e_we = 1'b0;
        e_mask = 32'd0;
      end
      if (ex) begin
        n_flush = 0;
        ptr = 0;
      end
      m_flush_prev = m_flush;
      m_flush = n_flush;
      tick();
      n_cmp++;
      if (wr_en !== e_we || commit_mask !== e_mask) begin
        n_err++; $display("FAIL rand_wb c=%0d got en=%b m=%h want %b/%h",
                          c, wr_en, commit_mask, e_we, e_mask);
      end
      if (e_we) begin
        n_cmp++;
        if (wr_addr !== e_addr || wr_data !== e_data) begin
          n_err++; $display("FAIL rand_data c=%0d got %0d/%h want %0d/%h",
                            c, wr_addr, wr_data, e_addr, e_data);
        end
      end
      n_cmp++;
      if (flush_req !== m_flush) begin
        n_err++; $display("FAIL rand_flush c=%0d got %b want %b", c, flush_req, m_flush);
      end
      if (m_flush) begin
        n_cmp++;
        if (redirect_pc !== e_pc) begin
          n_err++; $display("FAIL rand_pc c=%0d got %h want %h", c, redirect_pc, e_pc);
        end
      end
`ifdef HSV_COMMIT_RETIRE_COUNT_EN
      n_cmp++;
      if (retired_count !== 64'(m_ret)) begin
        n_err++; $display("FAIL rand_retired c=%0d got %0d want %0d", c, retired_count, m_ret);
      end
`endif
    end
    idle();
  endtask

  initial begin
    rst_core     = 1'b1;
    unit_valid_i = '0;
    unit_data_i  = '0;
    flush_ack    = 1'b0;
    #2;
    test_reset();
    test_single();
    test_x0();
    test_round_robin();
    test_redirect();
    test_stale_ack();
    test_reset_mid_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hsv_core_commit.md
Name: hsv_core_commit

Overview:
- Commit/writeback stage: the consuming end of the issue → exec-mem pipeline.
- Accepts one result per cycle from the five execution-unit result channels (alu, foo, mem, branch, ctrlstatus) over valid/ready.
- Writes the register file and returns commit_mask to issue to clear hazards.
- On a redirecting result (branch taken, trap), it runs the flush_req/flush_ack handshake with the front end.

Parameters:
- NUM_UNITS, 5, number of result channels; index 0=alu, 1=foo, 2=mem, 3=branch, 4=ctrlstatus.
- COUNT_W, 64, retired-instruction counter width (used only with the optional feature).

Ports:
- clk_core  in  1  core clock.
- rst_core  in  1  synchronous, active-high reset.
- unit_valid_i  in  NUM_UNITS  per-unit result valid.
- unit_ready_o  out  NUM_UNITS  per-unit result ready.
- unit_data_i  in  NUM_UNITS x $bits(commit_data_t)  per-unit result {rd, result, wb_en, redirect, redirect_pc}.
- wr_addr  out  5  regfile write address.
- wr_data  out  32  regfile write data.
- wr_en  out  1  regfile write enable.
- commit_mask  out  32  one-hot of the committed rd; drives issue hazard clear.
- flush_req  out  1  flush request to the front end / issue.
- flush_ack  in  1  flush acknowledge.
- redirect_pc  out  32  target PC, valid while flush_req=1.
- retired_count  out  COUNT_W  only exists when HSV_COMMIT_RETIRE_COUNT_EN is defined.

Behaviour:
- Reset (rst_core=1 at a clk_core edge):
  - wr_en=0, wr_addr=0, wr_data=0, commit_mask=0, flush_req=0, redirect_pc=0.
  - unit_ready_o=0 during the reset cycle.
  - State=RUN; arbiter pointer=0.
  - Reset overrides everything, including mid-flush.
- Arbitration (RUN only):
  - Round-robin among asserted unit_valid_i, starting at the pointer.
  - unit_ready_o is one-hot on the granted unit and 0 elsewhere; a transfer is valid & ready.
  - After a grant to unit k, the pointer becomes (k+1) mod NUM_UNITS.
  - No valids: no grant, pointer unchanged.
  - unit_ready_o depends only on state, pointer and unit_valid_i, with no combinational path from outputs.
- Writeback, latency 1 cycle:
  - A transfer in cycle N drives wr_en/wr_addr/wr_data/commit_mask in cycle N+1, all registered, for exactly one cycle.
  - wr_en = wb_en & (rd != 0).
  - commit_mask = wr_en ? (32'b1 << rd) : 0.
  - A write to x0 or with wb_en=0 produces no write and a zero mask, but still counts as retired.
- State machine:
  - RUN: as above. A transfer with redirect=1 moves to FLUSH next cycle. Its own writeback is still performed in N+1. redirect_pc is latched from the entry.
  - FLUSH: flush_req=1 and unit_ready_o all 0; results are held upstream, not dropped. Exit to RUN on the first cycle where flush_ack=1 and flush_req was already 1 in the previous cycle. This ignores a stale ack, since issue's ack lags req by one cycle.
  - On exit, flush_req drops the same edge; the pointer resets to 0.
- Simultaneous events: a redirect from one unit and valids on others in the same cycle: only the granted one transfers, and the others wait through the flush.
- Upstream skid buffers are flushed by flush_req. Commit does not discard anything itself.

Optional Feature:
- HSV_COMMIT_RETIRE_COUNT_EN defined:
  - retired_count port and register exist.
  - Reset to 0; increments by 1 on each transfer.
  - Wraps modulo 2^COUNT_W.
- Not defined: the port and register are absent, and behaviour is otherwise identical.

Decomposition:
- hsv_core_pkg gains:
  - commit_data_t (rd reg_addr, result word, wb_en, redirect, redirect_pc word).
  - commit_state_t enum {COMMIT_RUN, COMMIT_FLUSH}.
  - NUM_COMMIT_UNITS=5.
- One sub-module: hsv_core_commit_rr_arbiter (NUM_UNITS request → one-hot grant, pointer register, advance input).

Test Plan:
- Single transfer: alu valid, rd=5, result=32'hDEADBEEF, wb_en=1 → next cycle wr_en=1, wr_addr=5, wr_data=DEADBEEF, commit_mask=32'h20, all for one cycle.
- x0 suppression: rd=0, wb_en=1 → wr_en=0, commit_mask=0; with the feature, retired_count increments to 1.
- Round-robin: all five valid held for 10 cycles → grant order 0,1,2,3,4,0,1,2,3,4 and no unit starves.
- Redirect: branch result with rd=1, redirect=1, redirect_pc=32'h80000100 →
  - next cycle: write of x1 and flush_req=1, redirect_pc=80000100, all ready 0;
  - ack returned one cycle later → flush_req drops and RUN resumes with the pointer at 0.
- Stale ack: flush_ack held 1 on FLUSH entry → flush_req stays high for at least 2 cycles.
- Reset mid-flush: rst_core asserted in FLUSH → next cycle flush_req=0, state RUN, all outputs at reset values.
